// File: rtl/down_counter_4bit.sv
// -----------------------------------------------------------------------------
// down_counter_4bit
//
// Purpose:
//   Cascadable 4-bit synchronous down counter with parallel load, dual count
//   enables (CEP/CET), a borrow-style terminal count for chaining stages, and
//   a registered one-cycle underflow pulse. On underflow the counter either
//   wraps to 4'hF (AUTO_RELOAD = 0) or reloads the value captured by the most
//   recent parallel load (AUTO_RELOAD = 1).
//
// Parameters:
//   AUTO_RELOAD : 0 = wrap 0 -> 15 on underflow, 1 = reload from r_rld.
//
// Ports:
//   i_cp   in   1  clock, all state changes on the rising edge
//   i_sr   in   1  asynchronous active-high reset (clears Q, RLD and UF)
//   i_p    in   4  parallel load data, sampled only on a load edge
//   i_pe   in   1  parallel load enable (synchronous, highest priority)
//   i_cep  in   1  count enable, parallel
//   i_cet  in   1  count enable, trickle; also gates o_tc
//   o_q    out  4  counter value (registered)
//   o_tc   out  1  terminal count = i_cet AND (Q == 0), combinational
//   o_uf   out  1  registered underflow pulse
// -----------------------------------------------------------------------------
module down_counter_4bit #(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic       i_cp,
    input  logic       i_sr,
    input  logic [3:0] i_p,
    input  logic       i_pe,
    input  logic       i_cep,
    input  logic       i_cet,
    output logic [3:0] o_q,
    output logic       o_tc,
    output logic       o_uf
);

    // Operation selected for the coming edge, in strict priority order.
    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_COUNT = 2'd2
    } op_e;

    logic [3:0] r_q;
    logic [3:0] r_rld;
    logic       r_uf;

    op_e        w_op;
    logic       w_at_zero;
    logic [3:0] w_q_next;
    logic [3:0] w_rld_next;
    logic       w_uf_next;

    assign w_at_zero = (r_q == 4'h0);

    // Operation decode: load beats count, count needs both enables.
    always_comb begin
        w_op = OP_HOLD;
        if (i_pe) begin
            w_op = OP_LOAD;
        end else if (i_cep && i_cet) begin
            w_op = OP_COUNT;
        end else begin
            w_op = OP_HOLD;
        end
    end

    // Next-state computation for the counter, reload and underflow registers.
    always_comb begin
        w_q_next   = r_q;
        w_rld_next = r_rld;
        w_uf_next  = 1'b0;
        case (w_op)
            OP_LOAD: begin
                w_q_next   = i_p;
                w_rld_next = i_p;
                w_uf_next  = 1'b0;
            end
            OP_COUNT: begin
                if (w_at_zero) begin
                    // Underflow: the reload value is never touched by counting.
                    w_q_next  = AUTO_RELOAD ? r_rld : 4'hF;
                    w_uf_next = 1'b1;
                end else begin
                    w_q_next  = r_q - 4'd1;
                    w_uf_next = 1'b0;
                end
            end
            OP_HOLD: begin
                w_q_next  = r_q;
                w_uf_next = 1'b0;
            end
            default: begin
                w_q_next   = r_q;
                w_rld_next = r_rld;
                w_uf_next  = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous active-high clear.
    always_ff @(posedge i_cp or posedge i_sr) begin
        if (i_sr) begin
            r_q   <= 4'h0;
            r_rld <= 4'h0;
            r_uf  <= 1'b0;
        end else begin
            r_q   <= w_q_next;
            r_rld <= w_rld_next;
            r_uf  <= w_uf_next;
        end
    end

    assign o_q  = r_q;
    assign o_uf = r_uf;
    // Borrow for the next stage: independent of CEP and PE so a chain of
    // stages ripples its enable combinationally with no added latency.
    assign o_tc = i_cet & w_at_zero;

endmodule

// File: doc/down_counter_4bit.md
DOWN_COUNTER_4BIT -- requirements
Module: down_counter_4bit

Interface
REQ-001 Parameter: AUTO_RELOAD, default 0; 0 = wrap 0->15 on underflow, 1 = reload from the reload register on underflow.
REQ-002 CP  input  1  clock; all state changes on the rising edge.
REQ-003 SR  input  1  reset; asynchronous, active-high.
REQ-004 P  input  4  parallel load data.
REQ-005 PE  input  1  parallel load enable, active-high, synchronous.
REQ-006 CEP  input  1  count enable (parallel).
REQ-007 CET  input  1  count enable (trickle); also gates TC for cascading.
REQ-008 Q  output  4  counter value.
REQ-009 TC  output  1  terminal count (borrow) for cascading the next stage.
REQ-010 UF  output  1  registered underflow pulse.

Function
REQ-011 The block SHALL hold three registers: Q[3:0], RLD[3:0] (reload value, internal) and UF.
REQ-012 Per CP edge, the priority SHALL be: PE load > count (CEP=1 and CET=1) > hold.
REQ-013 Load (PE=1): Q <= P and RLD <= P, regardless of CEP/CET; UF <= 0.
REQ-014 Count with Q != 0: Q <= Q - 1; UF <= 0.
REQ-015 Count with Q = 0, AUTO_RELOAD=0: Q <= 4'hF; UF <= 1.
REQ-016 Count with Q = 0, AUTO_RELOAD=1: Q <= RLD; UF <= 1.
REQ-017 Hold (PE=0, and CEP=0 or CET=0): Q and RLD unchanged; UF <= 0.
REQ-018 UF SHALL be high for exactly one CP cycle after each underflow edge, and SHALL be high on consecutive cycles only if successive underflows occur (for example, RLD=0 with AUTO_RELOAD=1).
REQ-019 TC SHALL be combinational: TC = CET AND (Q == 0). TC SHALL be independent of CEP and PE.
REQ-020 Cascading: connect stage n TC to stage n+1 CET, and tie CEP in common. The cascaded chain SHALL then count down as one 4n-bit counter with no extra latency.
REQ-021 Arithmetic is modulo 16; no value outside 0..15 is representable.
REQ-022 RLD SHALL change only on load or reset; counting and underflow SHALL NOT modify it.
REQ-023 A load on the same edge where Q = 0 and the count is enabled: the load wins and UF <= 0.
REQ-024 P SHALL be sampled only on a load edge; P changes at any other time SHALL have no effect.

Reset
REQ-025 SR=1 SHALL immediately force Q=0, RLD=0 and UF=0, independent of CP.
REQ-026 While SR=1, TC SHALL equal CET, since Q=0.
REQ-027 SR asserted mid-count SHALL abort the count with no partial update.
REQ-028 After SR deasserts, the first CP rising edge SHALL be processed normally.
REQ-029 The reset value of every output SHALL be: Q=4'h0, UF=0, TC=CET.

Verification
REQ-030 Load-and-count: SR pulse, then PE=1 with P=5 for one edge, then CEP=CET=1 -> Q sequence 5,4,3,2,1,0,15 (AUTO_RELOAD=0); UF=1 only in the cycle where Q=15; TC=1 only while Q=0.
REQ-031 Auto-reload: AUTO_RELOAD=1, load P=3, then count for 10 edges -> Q sequence 3,2,1,0,3,2,1,0,3,2,1; UF pulses after each 0->3 transition.
REQ-032 Enable gating: Q=7, then CEP=0 and CET=1 for 4 edges -> Q stays 7 and TC=0; then CEP=1 and CET=0 -> Q stays 7.
REQ-033 Priority and simultaneity: Q=0 with CEP=CET=1 and PE=1, P=9 on the same edge -> Q=9, UF=0, RLD=9.
REQ-034 Async reset mid-count: assert SR between CP edges while Q=6 -> Q=0 and UF=0 before the next edge; with AUTO_RELOAD=1 the next count from 0 reloads to 0 and UF=1.
REQ-035 Cascade: two instances chained per REQ-020, both loaded with 0, then counted -> combined value 0x00, 0xFF, 0xFE, and so on; the upper stage decrements only on edges where the lower stage TC=1.
